// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M/RV64M multiply/divide sequencer.
//   mdop_e   : Funct3 encodings of the M-extension R-type operations
//   state_e  : sequencer FSM states
//   opcls_e  : multiply or divide datapath
//   ressel_e : which part of the final value becomes Result
//   mddec_t  : decoded instruction payload from muldiv_decode
package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdop_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic {
        CLS_MUL = 1'b0,
        CLS_DIV = 1'b1
    } opcls_e;

    typedef enum logic [1:0] {
        SEL_LO  = 2'd0,
        SEL_HI  = 2'd1,
        SEL_QUO = 2'd2,
        SEL_REM = 2'd3
    } ressel_e;

    typedef struct packed {
        logic    m_op;      // OP-class R-type with the MULDIV funct7
        opcls_e  cls;
        logic    a_signed;
        logic    b_signed;
        ressel_e sel;
    } mddec_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
//   master : pipeline side (drives instruction fields/operands/flush)
//   slave  : sequencer side (returns ready/stall/done/Result)
interface muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic            RType;
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] SrcA;
    logic [XLEN-1:0] SrcB;
    logic            flush;
    logic            ready;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] Result;

    modport master (
        output start, RType, ALUOp, Funct7, Funct3, SrcA, SrcB, flush,
        input  ready, stall, done, Result
    );

    modport slave (
        input  start, RType, ALUOp, Funct7, Funct3, SrcA, SrcB, flush,
        output ready, stall, done, Result
    );
endinterface

// File: rtl/muldiv_decode.sv
// Combinational decode of the M-extension R-type instructions.
//   RType/ALUOp/Funct7/Funct3 : instruction fields from the controller
//   dec                       : M-op flag, datapath class, operand signedness,
//                               result-part select
module muldiv_decode
    import muldiv_pkg::*;
(
    input  logic       RType,
    input  logic [1:0] ALUOp,
    input  logic [6:0] Funct7,
    input  logic [2:0] Funct3,
    output mddec_t     dec
);

    mdop_e op;
    assign op = mdop_e'(Funct3);

    // Operation table: low product half is sign-agnostic, so MUL runs unsigned
    always_comb begin
        dec      = '0;
        dec.m_op = RType && (ALUOp == ALUOP_RTYPE) && (Funct7 == FUNCT7_MULDIV);
        unique case (op)
            OP_MUL:    begin dec.cls = CLS_MUL; dec.sel = SEL_LO;  end
            OP_MULH:   begin dec.cls = CLS_MUL; dec.sel = SEL_HI;
                             dec.a_signed = 1'b1; dec.b_signed = 1'b1; end
            OP_MULHSU: begin dec.cls = CLS_MUL; dec.sel = SEL_HI;
                             dec.a_signed = 1'b1; end
            OP_MULHU:  begin dec.cls = CLS_MUL; dec.sel = SEL_HI;  end
            OP_DIV:    begin dec.cls = CLS_DIV; dec.sel = SEL_QUO;
                             dec.a_signed = 1'b1; dec.b_signed = 1'b1; end
            OP_DIVU:   begin dec.cls = CLS_DIV; dec.sel = SEL_QUO; end
            OP_REM:    begin dec.cls = CLS_DIV; dec.sel = SEL_REM;
                             dec.a_signed = 1'b1; dec.b_signed = 1'b1; end
            OP_REMU:   begin dec.cls = CLS_DIV; dec.sel = SEL_REM; end
            default:   begin dec.cls = CLS_MUL; dec.sel = SEL_LO;  end
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer beside the execute-stage ALU.
//   clk, rst_n : clock and synchronous active-low reset
//   bus.slave  : start/RType/ALUOp/Funct7/Funct3/SrcA/SrcB/flush in,
//                ready (idle), stall (combinational hold), done (one-cycle
//                pulse) and Result out
// Multiplies by shift-add and divides by restoring division on operand
// magnitudes, XLEN iterations each, then applies sign correction in FIX.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_seq_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    state_e           state;
    state_e           state_nxt;
    mddec_t           dec;
    logic             is_m;

    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;      // MUL: {product hi, multiplier}; DIV: {remainder, quotient}
    logic [XLEN-1:0]  opnd;     // multiplicand or divisor magnitude
    logic [XLEN-1:0]  a_raw;    // original rs1, needed for remainder-by-zero
    ressel_e          sel_q;
    logic             neg_q;
    logic             zero_q;
    logic             ovf_q;

    logic             ready_q;
    logic             done_q;
    logic [XLEN-1:0]  result_q;

    logic             accept;
    logic             step_mul;
    logic             step_div;
    logic             do_fix;
    logic             last_iter;

    muldiv_decode u_decode (
        .RType  (bus.RType),
        .ALUOp  (bus.ALUOp),
        .Funct7 (bus.Funct7),
        .Funct3 (bus.Funct3),
        .dec    (dec)
    );

    assign is_m      = bus.start && dec.m_op;
    assign last_iter = (cnt == CNT_W'(XLEN - 1));

    // Accept-time operand preparation
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic            neg_res;

    assign a_neg    = dec.a_signed && bus.SrcA[XLEN-1];
    assign b_neg    = dec.b_signed && bus.SrcB[XLEN-1];
    assign a_mag    = a_neg ? -bus.SrcA : bus.SrcA;
    assign b_mag    = b_neg ? -bus.SrcB : bus.SrcB;
    assign div_zero = (dec.cls == CLS_DIV) && (bus.SrcB == '0);
    assign div_ovf  = (dec.cls == CLS_DIV) && dec.a_signed &&
                      (bus.SrcA == MIN_INT) && (bus.SrcB == '1);
    assign special  = div_zero || div_ovf;
    // Remainder takes the dividend's sign; everything else the XOR of signs
    assign neg_res  = (dec.sel == SEL_REM) ? a_neg : (a_neg ^ b_neg);

    // One shift-add step: conditionally add multiplicand to the high half, shift right
    logic [XLEN:0]    mul_sum;
    logic [ACC_W-1:0] mul_nxt;
    assign mul_sum = {1'b0, acc[ACC_W-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nxt = {mul_sum, acc[XLEN-1:1]};

    // One restoring-division step: shift in next dividend bit, trial-subtract
    logic [XLEN:0]    div_rsh;
    logic [XLEN:0]    div_diff;
    logic [ACC_W-1:0] div_nxt;
    assign div_rsh  = {acc[ACC_W-1:XLEN], acc[XLEN-1]};
    assign div_diff = div_rsh - {1'b0, opnd};
    assign div_nxt  = div_diff[XLEN] ? {div_rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    // Sign correction and result-part selection
    logic [ACC_W-1:0] prod_fix;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;
    logic [XLEN-1:0]  fix_res;

    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = neg_q ? -acc[ACC_W-1:XLEN] : acc[ACC_W-1:XLEN];

    always_comb begin
        fix_res = '0;
        unique case (sel_q)
            SEL_LO:  fix_res = prod_fix[XLEN-1:0];
            SEL_HI:  fix_res = prod_fix[ACC_W-1:XLEN];
            SEL_QUO: fix_res = zero_q ? '1 : (ovf_q ? MIN_INT : quo_fix);
            SEL_REM: fix_res = zero_q ? a_raw : (ovf_q ? '0 : rem_fix);
            default: fix_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; flush overrides every transition
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (is_m) begin
                    if (dec.cls == CLS_MUL) begin
                        state_nxt = ST_MUL;
                    end else begin
                        state_nxt = special ? ST_FIX : ST_DIV;
                    end
                end
            end
            ST_MUL:  if (last_iter) state_nxt = ST_FIX;
            ST_DIV:  if (last_iter) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_nxt = ST_IDLE;
        end
    end

    // FSM output decode: datapath strobes
    always_comb begin
        accept   = 1'b0;
        step_mul = 1'b0;
        step_div = 1'b0;
        do_fix   = 1'b0;
        unique case (state)
            ST_IDLE: accept   = is_m;
            ST_MUL:  step_mul = 1'b1;
            ST_DIV:  step_div = 1'b1;
            ST_FIX:  do_fix   = 1'b1;
            default: ;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            sel_q    <= SEL_LO;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (bus.flush) begin
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            ready_q <= (state_nxt == ST_IDLE);
            done_q  <= do_fix;
            if (accept) begin
                cnt    <= '0;
                acc    <= {{XLEN{1'b0}}, (dec.cls == CLS_MUL) ? b_mag : a_mag};
                opnd   <= (dec.cls == CLS_MUL) ? a_mag : b_mag;
                a_raw  <= bus.SrcA;
                sel_q  <= dec.sel;
                neg_q  <= neg_res;
                zero_q <= div_zero;
                ovf_q  <= div_ovf;
            end
            if (step_mul || step_div) begin
                cnt <= cnt + CNT_W'(1);
                acc <= step_mul ? mul_nxt : div_nxt;
            end
            if (do_fix) begin
                result_q <= fix_res;
            end
        end
    end

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.Result = result_q;
    assign bus.stall  = is_m && (state != ST_DONE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (XLEN=32): directed cases for signs,
// special divides, flush/reset aborts and non-M instructions, plus random
// operations checked against an arithmetic reference model.
module tb_muldiv_seq;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_seq_if #(.XLEN(XLEN)) bus ();

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] last_res = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural RISC-V M results from 64-bit integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p  = '0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    task automatic drive_instr(input logic st, input logic rt, input logic [1:0] aop,
                               input logic [6:0] f7, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] b);
        bus.start  = st;
        bus.RType  = rt;
        bus.ALUOp  = aop;
        bus.Funct7 = f7;
        bus.Funct3 = f3;
        bus.SrcA   = a;
        bus.SrcB   = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one M op, hold it until done, and check result, latency and stall
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        logic got_done;
        logic stall_ok;
        @(negedge clk);
        drive_instr(1'b1, 1'b1, 2'b10, 7'b0000001, f3, a, b);
        #1;
        stall_ok = bus.stall;
        @(posedge clk);
        lat = 0;
        got_done = 1'b0;
        for (int i = 0; i < 100 && !got_done; i++) begin
            #1;
            lat++;
            if (bus.done) begin
                got_done = 1'b1;
            end else begin
                if (bus.stall !== 1'b1) stall_ok = 1'b0;
                bus.SrcA = $urandom;
                bus.SrcB = $urandom;
                @(posedge clk);
            end
        end
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, " result"}, bus.Result, exp_res);
        check_eq({tag, " stall held"}, stall_ok, 1'b1);
        check_eq({tag, " stall at done"}, bus.stall, 1'b0);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_eq({tag, " done pulse width"}, bus.done, 1'b0);
        check_eq({tag, " ready after"}, bus.ready, 1'b1);
        last_res = exp_res;
        if (!got_done) do_reset();
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic        seen_done;
        int          r;

        rst_n     = 1'b0;
        bus.flush = 1'b0;
        drive_instr(1'b0, 1'b0, 2'b00, 7'b0, 3'b0, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reset ready", bus.ready, 1'b1);
        check_eq("reset done", bus.done, 1'b0);
        check_eq("reset result", bus.Result, 32'h0);
        check_eq("reset stall", bus.stall, 1'b0);

        run_op("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
        run_op("mulh min*min", 3'd1, MIN32, MIN32, 32'h4000_0000, 34);
        run_op("mulhu min*min", 3'd3, MIN32, MIN32, 32'h4000_0000, 34);
        run_op("mulhsu min*min", 3'd2, MIN32, MIN32, 32'hC000_0000, 34);
        run_op("divu 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("rem 5/0", 3'd6, 32'd5, 32'd0, 32'd5, 2);
        run_op("div ovf", 3'd4, MIN32, 32'hFFFF_FFFF, MIN32, 2);
        run_op("rem ovf", 3'd6, MIN32, 32'hFFFF_FFFF, 32'd0, 2);
        run_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        run_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        run_op("remu big/2", 3'd7, 32'hFFFF_FFF9, 32'd2, 32'd1, 34);

        // Flush sampled on the 10th edge after accept of a MUL
        @(negedge clk);
        drive_instr(1'b1, 1'b1, 2'b10, 7'b0000001, 3'd0, 32'h1234, 32'h5678);
        @(posedge clk);
        #1;
        check_eq("mul busy ready", bus.ready, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("flush ready", bus.ready, 1'b1);
        bus.flush = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1'b1;
        end
        check_eq("flush no done", seen_done, 1'b0);
        check_eq("flush result kept", bus.Result, last_res);
        run_op("mul 3*4 after flush", 3'd0, 32'd3, 32'd4, 32'd12, 34);

        // Reset in the middle of a DIV
        @(negedge clk);
        drive_instr(1'b1, 1'b1, 2'b10, 7'b0000001, 3'd4, 32'd1000, 32'd7);
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst mid-div result", bus.Result, 32'h0);
        check_eq("rst mid-div ready", bus.ready, 1'b1);
        check_eq("rst mid-div done", bus.done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;

        // Non-M instructions never stall or get accepted
        @(negedge clk);
        drive_instr(1'b1, 1'b1, 2'b10, 7'b0000000, 3'd0, 32'd9, 32'd9);
        #1;
        check_eq("add stall", bus.stall, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("add ready", bus.ready, 1'b1);
        @(negedge clk);
        drive_instr(1'b1, 1'b0, 2'b10, 7'b0000001, 3'd4, 32'd9, 32'd0);
        #1;
        check_eq("addi stall", bus.stall, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("addi ready", bus.ready, 1'b1);
        @(negedge clk);
        drive_instr(1'b0, 1'b1, 2'b10, 7'b0000001, 3'd0, 32'd9, 32'd9);
        #1;
        check_eq("no start stall", bus.stall, 1'b0);
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || !bus.ready) seen_done = 1'b1;
        end
        check_eq("non-M no activity", seen_done, 1'b0);
        check_eq("non-M result kept", bus.Result, 32'h0);

        // Random operations against the reference model
        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom_range(0, 7));
            r  = int'($urandom_range(0, 9));
            a  = $urandom;
            b  = $urandom;
            if (r == 0) b = 32'd0;
            if (r == 1) begin a = MIN32; b = 32'hFFFF_FFFF; end
            if (r == 2) begin a = 32'($signed(8'($urandom))); b = 32'($signed(4'($urandom))); end
            run_op($sformatf("rand%0d f3=%0d", n, f3), f3, a, b, ref_model(f3, a, b),
                   (f3[2] && (b == 0 || ((f3 == 3'd4 || f3 == 3'd6) && a == MIN32 && b == 32'hFFFF_FFFF))) ? 2 : 34);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
